// File: rtl/reaction_pkg.sv
// reaction_pkg
//   Shared types and constants for the reaction-timer measurement core.
//   - rt_state_e : controller states (IDLE, WAIT, STIM, DONE, FAULT)
//   - LFSR_TAPS  : Galois feedback taps of the delay randomiser
//   - LFSR_SEED  : LFSR value after reset
//   - lfsr_next  : one Galois shift step
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    STIM  = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } rt_state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Right-shifting Galois step: the bit shifted out selects the tap XOR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic [15:0] nxt;
    if (cur[0]) begin
      nxt = (cur >> 1) ^ LFSR_TAPS;
    end else begin
      nxt = cur >> 1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Two-flop synchronizer, stable-count debouncer and rising-edge detector
//   for the operator button.
//   Ports:
//     clk_i         clock
//     rst_ni        asynchronous active-low reset
//     btn_async_i   raw asynchronous button level (active high)
//     press_pulse_o one-cycle pulse when the debounced level rises
//   The debounced level changes only after DEBOUNCE_CYCLES consecutive
//   synchronized samples that differ from it; the press pulse is registered
//   on the same edge the level rises, so a level already high produces no
//   pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_async_i,
  output logic press_pulse_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Stability counter: runs while the synchronized input disagrees with the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Synchronizer, debounce state and press pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_async_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_pulse_o = press_q;

endmodule

// File: rtl/reaction_timer_core.sv
// reaction_timer_core
//   Measurement core of the reaction tester: after start it waits
//   base_delay_ms + (lfsr & rand_mask) milliseconds, lights stim_led and
//   times the debounced button press in milliseconds.
//   Optional feature macro: REACTION_TIMEOUT_EN (reaction timeout of
//   TIMEOUT_MS; when undefined the count saturates and timeout is 0).
//   Ports:
//     ACLK, ARESETN       clock, asynchronous active-low reset
//     start, abort        one-cycle commands (abort wins)
//     base_delay_ms       minimum pre-stimulus delay
//     rand_mask           mask applied to the LFSR for the random delay part
//     btn_async           raw button
//     stim_led, busy      registered state indications
//     result_ms           last measured reaction time (held until overwritten)
//     result_valid, early, timeout  result flags (levels)
//     event_pulse         one cycle on entry to DONE or FAULT
module reaction_timer_core
  import reaction_pkg::*;
#(
  parameter int unsigned TICK_CYCLES     = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 200000,
  parameter int unsigned RESULT_W        = 16,
  parameter int unsigned TIMEOUT_MS      = 2000
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                start,
  input  logic                abort,
  input  logic [15:0]         base_delay_ms,
  input  logic [15:0]         rand_mask,
  input  logic                btn_async,
  output logic                stim_led,
  output logic                busy,
  output logic [RESULT_W-1:0] result_ms,
  output logic                result_valid,
  output logic                early,
  output logic                timeout,
  output logic                event_pulse
);

  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0]       PRESC_LAST  = PW'(TICK_CYCLES - 1);
  localparam logic [RESULT_W-1:0] TIMEOUT_VAL = RESULT_W'(TIMEOUT_MS);

  rt_state_e           state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [16:0]         delay_rem_q, delay_rem_d;
  logic [RESULT_W-1:0] count_q, count_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic                valid_q, valid_d;
  logic                early_q, early_d;
  logic                timeout_q, timeout_d;
  logic                stim_q, stim_d;
  logic                busy_q, busy_d;
  logic                event_q, event_d;
  logic                press_s;
  logic                tick_s;
  logic                entering_s;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_i        (ACLK),
    .rst_ni       (ARESETN),
    .btn_async_i  (btn_async),
    .press_pulse_o(press_s)
  );

  assign tick_s     = (presc_q == PRESC_LAST);
  assign entering_s = (state_d != state_q);

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides everything, press beats delay expiry/timeout.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE, FAULT: begin
          if (start) begin
            state_d = WAIT;
          end else begin
            state_d = state_q;
          end
        end
        WAIT: begin
          if (press_s) begin
            state_d = FAULT;
          end else if (delay_rem_q == 17'd0) begin
            state_d = STIM;
          end else begin
            state_d = WAIT;
          end
        end
        STIM: begin
          if (press_s) begin
            state_d = DONE;
`ifdef REACTION_TIMEOUT_EN
          end else if (count_q == TIMEOUT_VAL) begin
            state_d = FAULT;
`endif
          end else begin
            state_d = STIM;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and output next values, derived from the current and next state.
  always_comb begin
    lfsr_d      = lfsr_next(lfsr_q);
    delay_rem_d = delay_rem_q;
    count_d     = count_q;
    result_d    = result_q;
    valid_d     = valid_q;
    early_d     = early_q;
    timeout_d   = timeout_q;

    // Prescaler restarts on every state entry so each state begins a full tick.
    if (abort || entering_s) begin
      presc_d = '0;
    end else if (tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (abort) begin
      valid_d   = 1'b0;
      early_d   = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE, FAULT: begin
          if (start) begin
            delay_rem_d = {1'b0, base_delay_ms} + {1'b0, lfsr_q & rand_mask};
            valid_d     = 1'b0;
            early_d     = 1'b0;
            timeout_d   = 1'b0;
          end else begin
            delay_rem_d = delay_rem_q;
          end
        end
        WAIT: begin
          if (press_s) begin
            early_d = 1'b1;
          end else if (delay_rem_q == 17'd0) begin
            // Leaving for STIM: the reaction count starts from zero.
            count_d = '0;
          end else if (tick_s) begin
            delay_rem_d = delay_rem_q - 17'd1;
          end else begin
            delay_rem_d = delay_rem_q;
          end
        end
        STIM: begin
          if (press_s) begin
            // Capture the count as it stands, ignoring any same-cycle tick.
            result_d = count_q;
            valid_d  = 1'b1;
`ifdef REACTION_TIMEOUT_EN
          end else if (count_q == TIMEOUT_VAL) begin
            result_d  = TIMEOUT_VAL;
            timeout_d = 1'b1;
`endif
          end else if (tick_s && (count_q != '1)) begin
            count_d = count_q + RESULT_W'(1);
          end else begin
            count_d = count_q;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end

    stim_d  = (state_d == STIM);
    busy_d  = (state_d == WAIT) || (state_d == STIM);
    event_d = entering_s && ((state_d == DONE) || (state_d == FAULT));
  end

  // Datapath and registered output flops.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      lfsr_q      <= LFSR_SEED;
      presc_q     <= '0;
      delay_rem_q <= 17'd0;
      count_q     <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      early_q     <= 1'b0;
      timeout_q   <= 1'b0;
      stim_q      <= 1'b0;
      busy_q      <= 1'b0;
      event_q     <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      presc_q     <= presc_d;
      delay_rem_q <= delay_rem_d;
      count_q     <= count_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      early_q     <= early_d;
      timeout_q   <= timeout_d;
      stim_q      <= stim_d;
      busy_q      <= busy_d;
      event_q     <= event_d;
    end
  end

  assign stim_led     = stim_q;
  assign busy         = busy_q;
  assign result_ms    = result_q;
  assign result_valid = valid_q;
  assign early        = early_q;
  assign timeout      = timeout_q;
  assign event_pulse  = event_q;

endmodule

// File: tb/tb_reaction_timer_core.sv
// tb_reaction_timer_core
//   Scoreboard bench: each run pushes the expected result record when its
//   stimulus is driven; the event_pulse monitor pops and compares it.
module tb_reaction_timer_core;

  localparam int unsigned TICK = 10;
  localparam int unsigned DEB  = 4;
  localparam int unsigned TMO  = 50;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] base_delay_ms = 16'd0;
  logic [15:0] rand_mask = 16'd0;
  logic        btn_async = 1'b0;
  logic        stim_led, busy, result_valid, early, timeout, event_pulse;
  logic [15:0] result_ms;

  typedef struct packed {
    logic [15:0] res;
    logic        vld;
    logic        erl;
    logic        tmo;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   events = 0;
  logic stim_seen = 1'b0;
  int   ev0;

  reaction_timer_core #(
    .TICK_CYCLES(TICK), .DEBOUNCE_CYCLES(DEB), .RESULT_W(16), .TIMEOUT_MS(TMO)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .abort(abort),
    .base_delay_ms(base_delay_ms), .rand_mask(rand_mask), .btn_async(btn_async),
    .stim_led(stim_led), .busy(busy), .result_ms(result_ms),
    .result_valid(result_valid), .early(early), .timeout(timeout),
    .event_pulse(event_pulse)
  );

  always #5 ACLK = ~ACLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [15:0] r, input logic v, input logic e, input logic t);
    exp_t x;
    x.res = r; x.vld = v; x.erl = e; x.tmo = t;
    return x;
  endfunction

  // Scoreboard monitor: every event pulse consumes one expected record.
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (stim_led) stim_seen <= 1'b1;
      if (event_pulse) begin
        events <= events + 1;
        check_val("sb_nonempty", {31'd0, sb_q.size() > 0}, 32'd1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check_val("result_ms", {16'd0, result_ms}, {16'd0, mon_e.res});
          check_val("result_valid", {31'd0, result_valid}, {31'd0, mon_e.vld});
          check_val("early", {31'd0, early}, {31'd0, mon_e.erl});
          check_val("timeout", {31'd0, timeout}, {31'd0, mon_e.tmo});
        end
      end
    end
  end

  task automatic do_start(input logic [15:0] base, input logic [15:0] mask);
    @(negedge ACLK);
    base_delay_ms = base;
    rand_mask = mask;
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    check_val("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_stim(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge ACLK);
      if (stim_led) seen = 1'b1;
    end
    check_val("stim_wait", {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_event(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge ACLK);
      if (event_pulse) seen = 1'b1;
    end
    check_val("event_wait", {31'd0, seen}, 32'd1);
    check_val("stim_at_event", {31'd0, stim_led}, 32'd0);
    check_val("busy_at_event", {31'd0, busy}, 32'd0);
    @(negedge ACLK);
    check_val("event_one_cycle", {31'd0, event_pulse}, 32'd0);
  endtask

  task automatic release_btn();
    btn_async = 1'b0;
    repeat (10) @(negedge ACLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge ACLK);
    check_val("rst_stim", {31'd0, stim_led}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_result", {16'd0, result_ms}, 32'd0);
    check_val("rst_flags", {29'd0, result_valid, early, timeout}, 32'd0);
    check_val("rst_event", {31'd0, event_pulse}, 32'd0);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    check_val("idle_busy", {31'd0, busy}, 32'd0);

    // Normal run: press so that the debounced edge lands in tick 7
    do_start(16'd3, 16'd0);
    wait_stim(100);
    sb_q.push_back(mk_exp(16'd7, 1'b1, 1'b0, 1'b0));
    repeat (68) @(negedge ACLK);
    btn_async = 1'b1;
    wait_event(30);
    release_btn();

    // Early press during WAIT; result_ms keeps the previous value
    stim_seen = 1'b0;
    do_start(16'd20, 16'd0);
    sb_q.push_back(mk_exp(16'd7, 1'b0, 1'b1, 1'b0));
    repeat (50) @(negedge ACLK);
    btn_async = 1'b1;
    wait_event(20);
    check_val("early_no_stim", {31'd0, stim_seen}, 32'd0);
    release_btn();

    // Zero delay: STIM two cycles after start, then abort
    do_start(16'd0, 16'd0);
    check_val("zero_stim_n1", {31'd0, stim_led}, 32'd0);
    @(negedge ACLK);
    check_val("zero_stim_n2", {31'd0, stim_led}, 32'd1);
    ev0 = events;
    abort = 1'b1;
    @(negedge ACLK);
    abort = 1'b0;
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_stim", {31'd0, stim_led}, 32'd0);
    check_val("abort_held_result", {16'd0, result_ms}, 32'd7);
    check_val("abort_flags", {29'd0, result_valid, early, timeout}, 32'd0);
    repeat (10) @(negedge ACLK);
    check_val("abort_no_event", events, ev0);

    // start and abort together: stay in IDLE
    base_delay_ms = 16'd0;
    start = 1'b1;
    abort = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    abort = 1'b0;
    check_val("sa_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge ACLK);
    check_val("sa_stim", {31'd0, stim_led}, 32'd0);
    check_val("sa_no_event", events, ev0);

    // Bounce: a 2-cycle glitch during WAIT is ignored, then a real press
    do_start(16'd5, 16'd0);
    repeat (5) @(negedge ACLK);
    btn_async = 1'b1;
    repeat (2) @(negedge ACLK);
    btn_async = 1'b0;
    repeat (10) @(negedge ACLK);
    check_val("glitch_early", {31'd0, early}, 32'd0);
    check_val("glitch_busy", {31'd0, busy}, 32'd1);
    wait_stim(100);
    sb_q.push_back(mk_exp(16'd7, 1'b1, 1'b0, 1'b0));
    repeat (68) @(negedge ACLK);
    btn_async = 1'b1;
    wait_event(30);
    release_btn();

    // Button held through start is not a press; a later new press measures tick 1
    btn_async = 1'b1;
    repeat (10) @(negedge ACLK);
    do_start(16'd2, 16'd0);
    wait_stim(60);
    check_val("held_early", {31'd0, early}, 32'd0);
    sb_q.push_back(mk_exp(16'd1, 1'b1, 1'b0, 1'b0));
    btn_async = 1'b0;
    repeat (10) @(negedge ACLK);
    btn_async = 1'b1;
    wait_event(30);
    check_val("held_timeout_flag", {31'd0, timeout}, 32'd0);
    release_btn();

`ifdef REACTION_TIMEOUT_EN
    // Timeout: no press within TIMEOUT_MS
    do_start(16'd0, 16'd0);
    sb_q.push_back(mk_exp(16'(TMO), 1'b0, 1'b0, 1'b1));
    wait_event(TMO * TICK + 100);
`endif

    // Reset asserted mid-STIM clears outputs immediately
    do_start(16'd0, 16'd0);
    repeat (5) @(negedge ACLK);
    check_val("pre_rst_stim", {31'd0, stim_led}, 32'd1);
    ARESETN = 1'b0;
    #1;
    check_val("arst_stim", {31'd0, stim_led}, 32'd0);
    check_val("arst_busy", {31'd0, busy}, 32'd0);
    check_val("arst_result", {16'd0, result_ms}, 32'd0);
    check_val("arst_flags", {29'd0, result_valid, early, timeout}, 32'd0);
    check_val("arst_event", {31'd0, event_pulse}, 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (3) @(negedge ACLK);
    check_val("post_rst_busy", {31'd0, busy}, 32'd0);

    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
